// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready and
// emits it one bit per clock on dout, framed by dout_valid and last.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             accept_s;

  // Bit that leaves the word next, depending on transmit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with the outgoing bit removed, so the next bit sits at the head.
  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1'b1) : (w >> 1'b1);
  endfunction

  assign din_ready  = (state_q == IDLE) | ((state_q == SHIFT) & last_q);
  assign accept_s   = din_valid & din_ready;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign last       = last_q;
  assign busy       = busy_q;

  // Next-state and next-output computation for the IDLE/SHIFT framer.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    last_d       = 1'b0;
    busy_d       = 1'b0;
    case (state_q)
      IDLE, SHIFT: begin
        if (accept_s) begin
          // Loading also covers the final-bit cycle, giving gap-free streaming.
          state_d      = SHIFT;
          shreg_d      = drop_head(din);
          dout_d       = head_bit(din);
          cnt_d        = CW'(WIDTH - 1);
          dout_valid_d = 1'b1;
          last_d       = (WIDTH == 1);
          busy_d       = 1'b1;
        end else if ((state_q == SHIFT) && !last_q) begin
          state_d      = SHIFT;
          shreg_d      = drop_head(shreg_q);
          dout_d       = head_bit(shreg_q);
          cnt_d        = cnt_q - CW'(1);
          dout_valid_d = 1'b1;
          last_d       = (cnt_q == CW'(1));
          busy_d       = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset wins over accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: MSB-first, LSB-first and WIDTH=1 instances checked every
// cycle against a word/bit-index model, plus directed frames with literal expectations.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic [7:0] din;

  logic rdy [3];
  logic dq  [3];
  logic dv  [3];
  logic lst [3];
  logic bsy [3];

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model: per instance, whether a frame is shown, the word, and the index of the shown bit.
  bit       m_active [3];
  bit [7:0] m_word   [3];
  int       m_k      [3];
  int       m_w      [3];
  bit       m_msb    [3];

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy[0]),
    .dout(dq[0]), .dout_valid(dv[0]), .last(lst[0]), .busy(bsy[0]));

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy[1]),
    .dout(dq[1]), .dout_valid(dv[1]), .last(lst[1]), .busy(bsy[1]));

  piso_shift_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) u_one (
    .clk(clk), .rst(rst), .din(din[0:0]), .din_valid(din_valid), .din_ready(rdy[2]),
    .dout(dq[2]), .dout_valid(dv[2]), .last(lst[2]), .busy(bsy[2]));

  initial begin
    m_w[0] = 8; m_msb[0] = 1'b1;
    m_w[1] = 8; m_msb[1] = 1'b0;
    m_w[2] = 1; m_msb[2] = 1'b1;
    for (int d = 0; d < 3; d++) begin
      m_active[d] = 1'b0; m_word[d] = 8'h00; m_k[d] = 0;
    end
  end

  function automatic bit exp_ready(int d);
    return !m_active[d] || (m_k[d] == m_w[d] - 1);
  endfunction

  function automatic bit exp_dout(int d);
    int idx;
    if (!m_active[d]) return 1'b0;
    idx = m_msb[d] ? (m_w[d] - 1 - m_k[d]) : m_k[d];
    return m_word[d][idx];
  endfunction

  // Model advance on each rising edge, mirroring what the inputs demand.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst) begin
        m_active[d] <= 1'b0;
        m_k[d]      <= 0;
      end else if (m_active[d] && (m_k[d] < m_w[d] - 1)) begin
        m_k[d] <= m_k[d] + 1;
      end else if (din_valid && exp_ready(d)) begin
        m_active[d] <= 1'b1;
        m_word[d]   <= din;
        m_k[d]      <= 0;
      end else begin
        m_active[d] <= 1'b0;
      end
    end
    started <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("dout[%0d]", d), 32'(dq[d]), 32'(exp_dout(d)));
        chk($sformatf("dout_valid[%0d]", d), 32'(dv[d]), 32'(m_active[d]));
        chk($sformatf("last[%0d]", d), 32'(lst[d]), 32'(m_active[d] && (m_k[d] == m_w[d] - 1)));
        chk($sformatf("busy[%0d]", d), 32'(bsy[d]), 32'(m_active[d]));
        chk($sformatf("din_ready[%0d]", d), 32'(rdy[d]), 32'(exp_ready(d)));
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    rst = r; din_valid = v; din = d;
    @(negedge clk); #1;
  endtask

  logic [7:0]  cap_m, cap_l;
  logic [15:0] cap16;
  int          nvalid, nlast;

  initial begin
    rst = 1'b0; din_valid = 1'b1; din = 8'hFF;
    @(negedge clk); #1;
    // Reset held two cycles with a valid word present.
    drive(1'b0, 1'b1, 8'hFF);
    chk("reset_dout_valid", 32'(dv[0]), 32'd0);
    chk("reset_busy", 32'(bsy[0]), 32'd0);
    chk("reset_ready", 32'(rdy[0]), 32'd1);
    drive(1'b1, 1'b0, 8'hFF);
    chk("post_reset_no_frame", 32'(dv[0]), 32'd0);

    // MSB-first and LSB-first frames of 8'hC5 side by side.
    drive(1'b1, 1'b1, 8'hC5);
    cap_m = 8'h00; cap_l = 8'h00; nvalid = 0; nlast = 0;
    for (int i = 0; i < 8; i++) begin
      cap_m = {cap_m[6:0], dq[0]};
      cap_l = {cap_l[6:0], dq[1]};
      nvalid += int'(dv[0]);
      nlast  += int'(lst[0]);
      if (i == 7) chk("last_on_8th", 32'(lst[1]), 32'd1);
      drive(1'b1, 1'b0, 8'h00);
    end
    chk("msb_c5_bits", 32'(cap_m), 32'hC5);
    chk("lsb_c5_bits", 32'(cap_l), 32'hA3);
    chk("frame_len", 32'(nvalid), 32'd8);
    chk("last_count", 32'(nlast), 32'd1);
    chk("idle_after_frame", 32'(dv[0]), 32'd0);

    // Back-to-back words: 8'h0F held valid through the first frame.
    drive(1'b1, 1'b1, 8'hC5);
    cap16 = 16'h0000; nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      cap16 = {cap16[14:0], dq[0]};
      nvalid += int'(dv[0]);
      drive(1'b1, (i <= 7), 8'h0F);
    end
    chk("b2b_bits", 32'(cap16), 32'hC50F);
    chk("b2b_contiguous", 32'(nvalid), 32'd16);

    // din_valid toggling and din changing mid-frame must not disturb it.
    drive(1'b1, 1'b1, 8'hC5);
    cap_m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cap_m = {cap_m[6:0], dq[0]};
      drive(1'b1, (i < 7) ? logic'(i % 2) : 1'b0, 8'hAA);
    end
    chk("busy_ignore_bits", 32'(cap_m), 32'hC5);
    chk("busy_ignore_no_extra", 32'(dv[0]), 32'd0);

    // Reset after the third bit aborts the frame; a new word then sends cleanly.
    drive(1'b1, 1'b1, 8'hC5);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("abort_valid", 32'(dv[0]), 32'd0);
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    drive(1'b1, 1'b1, 8'h01);
    cap_m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cap_m = {cap_m[6:0], dq[0]};
      drive(1'b1, 1'b0, 8'h00);
    end
    chk("after_abort_01", 32'(cap_m), 32'h01);

    // Randomised traffic with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 49) != 0), logic'($urandom_range(0, 3) != 0),
            8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in/serial-out transmitter. It drives the single-bit data stream that our D flip-flop and serial-capture blocks sample on clk. It accepts a WIDTH-bit word through a valid/ready handshake and emits it on dout, one bit per clock. Framing is marked by dout_valid and last. Back-to-back words stream without gaps.

Parameters:
WIDTH, 8, word width in bits; legal range 1..32
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-low; sampled only on the rising edge of clk
din  input  WIDTH  parallel word to transmit
din_valid  input  1  din holds a word to send
din_ready  output  1  block can accept a word this cycle
dout  output  1  serial data bit, registered
dout_valid  output  1  dout carries a frame bit this cycle
last  output  1  dout carries the final bit of the current word
busy  output  1  a frame is in progress (state SHIFT)

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE, shift register=0, bit counter=0.
  - dout=0, dout_valid=0, last=0, busy=0.
  - din_ready is combinational and therefore reads 1 in the cycle after reset.
  - din_valid at a reset edge is ignored; no word is accepted.
- States: IDLE, SHIFT.
- din_ready = (state==IDLE) | (state==SHIFT & last). No other combinational paths to outputs.
- Accept = din_valid & din_ready at a rising edge with rst=1.
- IDLE:
  - dout=0, dout_valid=0, last=0.
  - On accept: load din into the shift register, drive the first bit onto dout, set dout_valid=1, set counter=WIDTH-1, set last=(WIDTH==1), go to SHIFT.
  - Latency: first bit is visible in the cycle after the accept edge.
- SHIFT, counter>0:
  - Each edge presents the next bit, decrements the counter, and sets last when the counter reaches 1→0.
  - din_valid is ignored because din_ready=0. din may change freely.
- SHIFT, last=1 (final bit on dout):
  - On accept: load the new word and present its first bit on the next cycle. dout_valid stays 1 with zero idle cycles.
  - With no accept: go to IDLE, and dout, dout_valid and last return to 0.
- Bit order:
  - MSB_FIRST=1: bits WIDTH-1 down to 0.
  - MSB_FIRST=0: bits 0 up to WIDTH-1.
- Frame length: exactly WIDTH dout_valid cycles per accepted word. last is high for exactly one of them.
- Counter width: $clog2(WIDTH) bits, minimum 1. It never wraps; it is reloaded only on accept.
- WIDTH=1: every frame is one cycle with last=1. din_ready stays high continuously, giving one word per clock.
- Reset mid-frame: the frame is aborted and the remaining bits are discarded. Outputs clear at that edge; no partial resume.
- Simultaneous reset and accept: reset wins.
- busy = (state==SHIFT), registered with the state.

Test Plan:
1. Reset with rst=0 for 2 cycles, din_valid=1, din=8'hFF -> dout=0, dout_valid=0, last=0, busy=0, no frame after release. din_ready=1 in the first cycle with rst=1.
2. MSB_FIRST=1, accept 8'hC5 -> starting the next cycle, dout=1,1,0,0,0,1,0,1 with dout_valid=1 for 8 cycles and last only on the 8th. Then IDLE, dout_valid=0.
3. MSB_FIRST=0, accept 8'hC5 -> dout=1,0,1,0,0,0,1,1, last on the 8th bit.
4. Back-to-back, MSB_FIRST=1: 8'hC5 accepted, then 8'h0F held valid and accepted during last -> 16 contiguous dout_valid cycles; second word bits 0,0,0,0,1,1,1,1. din_ready high only in IDLE and last cycles.
5. During the 8'hC5 frame, toggle din_valid and change din to 8'hAA while busy -> output sequence unchanged, no extra frame.
6. rst=0 for 1 cycle after the 3rd bit of 8'hC5 -> next cycle dout_valid=0, busy=0. Remaining bits never appear. A new word 8'h01 sends cleanly afterwards: 0,0,0,0,0,0,0,1.
